// File: rtl/abc_stim_seq_pkg.sv
// Shared encodings and the stimulus vector table for the ABC stimulus sequencer.
// Checkers may import this package to reuse the same table.
package abc_stim_seq_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_DRIVE  = 2'd1,
    STATE_FINISH = 2'd2
  } state_t;

  // Entry i is {a,b,c} for vector i; entry 0 sits in the low three bits.
  localparam logic [7:0][2:0] VEC_TABLE = {
    3'b010, 3'b111, 3'b001, 3'b110, 3'b101, 3'b011, 3'b100, 3'b000
  };

  function automatic logic [2:0] vec_lookup(input logic [2:0] idx);
    return VEC_TABLE[idx];
  endfunction

endpackage

// File: rtl/abc_stim_seq_if.sv
// Stimulus/response bundle between the sequencer (master) and the stage under test
// plus its checker (slave).
interface abc_stim_seq_if;
  logic       start;
  logic       abort;
  logic       y_in;
  logic       a;
  logic       b;
  logic       c;
  logic [2:0] vec_idx;
  logic       busy;
  logic       done;
  logic [7:0] resp;
  logic       resp_valid;

  modport master (
    input  start, abort, y_in,
    output a, b, c, vec_idx, busy, done, resp, resp_valid
  );

  modport slave (
    output start, abort, y_in,
    input  a, b, c, vec_idx, busy, done, resp, resp_valid
  );
endinterface

// File: rtl/abc_stim_seq_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 and wraps, flagging the last
// hold cycle with tc. clr parks the count at zero.
module abc_stim_seq_hold_timer #(
  parameter int HOLD_CYCLES = 10,
  parameter int HOLD_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  logic [HOLD_W-1:0] cnt;

  assign tc = (cnt == HOLD_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/abc_stim_seq.sv
// Stimulus sequencer: walks {a,b,c} through the 8-entry vector table, holding each
// vector HOLD_CYCLES clocks and sampling y_in on the last hold cycle into resp.
//
// state        | meaning
// STATE_IDLE   | outputs parked at 000 / idx 0, waiting for start
// STATE_DRIVE  | a vector is driven; timer counts its hold cycles
// STATE_FINISH | one-cycle done pulse, resp published
module abc_stim_seq
  import abc_stim_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int HOLD_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  abc_stim_seq_if.master bus
);

  if ((HOLD_CYCLES < 2) || (HOLD_CYCLES > 255) || ((1 << HOLD_W) <= HOLD_CYCLES)) begin : g_bad_param
    $error("abc_stim_seq: HOLD_CYCLES must be 2..255 and fit in HOLD_W bits");
  end

  state_t     state, state_d;
  logic [2:0] abc, abc_d;
  logic [2:0] idx, idx_d;
  logic       busy, busy_d;
  logic       done, done_d;
  logic [7:0] resp, resp_d;
  logic       resp_valid, resp_valid_d;
  logic       tc;

  abc_stim_seq_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (state != STATE_DRIVE),
    .tc  (tc)
  );

  always_comb begin
    state_d      = state;
    abc_d        = abc;
    idx_d        = idx;
    busy_d       = busy;
    done_d       = 1'b0;
    resp_d       = resp;
    resp_valid_d = resp_valid;
    case (state)
      STATE_IDLE: begin
        if (bus.abort) begin
          resp_valid_d = 1'b0;
        end else if (bus.start) begin
          state_d      = STATE_DRIVE;
          idx_d        = 3'd0;
          abc_d        = vec_lookup(3'd0);
          busy_d       = 1'b1;
          resp_d       = 8'h00;
          resp_valid_d = 1'b0;
        end
      end
      STATE_DRIVE: begin
        // abort takes precedence even on a sampling cycle: the run is abandoned
        if (bus.abort) begin
          state_d      = STATE_IDLE;
          abc_d        = 3'b000;
          idx_d        = 3'd0;
          busy_d       = 1'b0;
          resp_valid_d = 1'b0;
        end else if (tc) begin
          resp_d[idx] = bus.y_in;
          if (idx == 3'd7) begin
            state_d      = STATE_FINISH;
            abc_d        = 3'b000;
            idx_d        = 3'd0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            resp_valid_d = 1'b1;
          end else begin
            idx_d = idx + 3'd1;
            abc_d = vec_lookup(idx + 3'd1);
          end
        end
      end
      STATE_FINISH: begin
        state_d = STATE_IDLE;
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STATE_IDLE;
      abc        <= 3'b000;
      idx        <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resp       <= 8'h00;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_d;
      abc        <= abc_d;
      idx        <= idx_d;
      busy       <= busy_d;
      done       <= done_d;
      resp       <= resp_d;
      resp_valid <= resp_valid_d;
    end
  end

  assign {bus.a, bus.b, bus.c} = abc;
  assign bus.vec_idx    = idx;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.resp       = resp;
  assign bus.resp_valid = resp_valid;

endmodule

// File: tb/tb_abc_stim_seq.sv
// Self-checking bench for abc_stim_seq: y_in comes from a selectable 3-input truth
// table, and expected responses are derived from the vector list and that table.
module tb_abc_stim_seq;

  localparam int H = 10;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] truth;
  logic       tog_mode;
  logic       tog;

  logic [2:0] tbl [8];

  abc_stim_seq_if bus ();

  abc_stim_seq #(.HOLD_CYCLES(H), .HOLD_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.y_in = tog_mode ? tog : truth[{bus.a, bus.b, bus.c}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] observe();
    return {bus.busy, bus.done, bus.resp_valid, bus.a, bus.b, bus.c, bus.vec_idx};
  endfunction

  task automatic test_reset();
    logic [8:0] obs;
    rst = 1'b1;
    tog_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.start = i[0];
      tog = ~tog;
      step();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    obs = observe();
    checks++;
    if (obs !== 9'd0 || bus.resp !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got %b resp %h, want 0 resp 00", obs, bus.resp);
    end
    for (int i = 0; i < 6; i++) begin
      tog = ~tog;
      step();
    end
    obs = observe();
    checks++;
    if (obs !== 9'd0 || bus.resp !== 8'h00) begin
      errors++;
      $display("FAIL reset_y_toggle: got %b resp %h, want 0 resp 00", obs, bus.resp);
    end
    tog_mode = 1'b0;
  endtask

  // One full run with y_in = f({a,b,c}); repulse_vec >= 0 re-pulses start mid-vector.
  task automatic run_seq(input string name, input logic [7:0] f, input int repulse_vec);
    logic [7:0] exp_resp;
    logic [8:0] obs;
    logic [8:0] expv;
    int         v;
    truth = f;
    for (int i = 0; i < 8; i++) exp_resp[i] = f[tbl[i]];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.resp !== 8'h00 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_clear: resp %h valid %b, want 00 0", name, bus.resp, bus.resp_valid);
    end
    for (int n = 0; n < 8 * H; n++) begin
      v = n / H;
      obs = observe();
      expv = {3'b100, tbl[v], 3'(v)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s_cycle%0d: got %b want %b", name, n, obs, expv);
      end
      bus.start = (repulse_vec >= 0 && n == repulse_vec * H + 2);
      step();
    end
    bus.start = 1'b0;
    obs = observe();
    checks++;
    if (obs !== 9'b011_000_000) begin
      errors++;
      $display("FAIL %s_finish: got %b want 011000000", name, obs);
    end
    checks++;
    if (bus.resp !== exp_resp) begin
      errors++;
      $display("FAIL %s_resp: got %h want %h", name, bus.resp, exp_resp);
    end
    step();
    obs = observe();
    checks++;
    if (obs !== 9'b001_000_000) begin
      errors++;
      $display("FAIL %s_after_done: got %b want 001000000", name, obs);
    end
    repeat (3) step();
    obs = observe();
    checks++;
    if (obs !== 9'b001_000_000 || bus.resp !== exp_resp) begin
      errors++;
      $display("FAIL %s_idle_hold: got %b resp %h want 001000000 resp %h", name, obs, bus.resp, exp_resp);
    end
  endtask

  task automatic test_parity();
    run_seq("parity", 8'h96, -1);
    checks++;
    if (bus.resp !== 8'hE2) begin
      errors++;
      $display("FAIL parity_E2: got %h want e2", bus.resp);
    end
  endtask

  task automatic test_constant();
    run_seq("const1", 8'hFF, -1);
    run_seq("const0", 8'h00, -1);
  endtask

  task automatic test_back_to_back_start();
    run_seq("repulse", 8'h96, 3);
  endtask

  task automatic test_abort();
    logic [8:0] obs;
    truth = 8'h96;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4 * H + 5) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    obs = observe();
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %b want 000000000", obs);
    end
    checks++;
    if (bus.resp !== 8'h02) begin
      errors++;
      $display("FAIL abort_partial_resp: got %h want 02", bus.resp);
    end
    repeat (2 * H) begin
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: done %b busy %b want 0 0", bus.done, bus.busy);
      end
    end
    run_seq("post_abort", 8'h96, -1);
  endtask

  task automatic test_start_abort_idle();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || {bus.a, bus.b, bus.c} !== 3'b000) begin
      errors++;
      $display("FAIL start_abort_idle: busy %b valid %b abc %b want 0 0 000",
               bus.busy, bus.resp_valid, {bus.a, bus.b, bus.c});
    end
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_stays_idle: busy %b want 0", bus.busy);
    end
  endtask

  task automatic test_rst_midrun();
    logic [8:0] obs;
    truth = 8'h96;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6 * H + 3) step();
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    obs = observe();
    checks++;
    if (obs !== 9'd0 || bus.resp !== 8'h00) begin
      errors++;
      $display("FAIL rst_midrun: got %b resp %h want 0 resp 00", obs, bus.resp);
    end
    repeat (2 * H) step();
    obs = observe();
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL rst_no_run: got %b want 000000000", obs);
    end
  endtask

  task automatic test_random();
    logic [7:0] f;
    for (int r = 0; r < 4; r++) begin
      f = 8'($urandom);
      run_seq("random", f, -1);
    end
  endtask

  initial begin
    tbl = '{3'b000, 3'b100, 3'b011, 3'b101, 3'b110, 3'b001, 3'b111, 3'b010};
    checks = 0;
    errors = 0;
    rst = 1'b1;
    tog = 1'b0;
    tog_mode = 1'b0;
    truth = 8'h00;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_parity();
    test_constant();
    test_back_to_back_start();
    test_start_abort_idle();
    test_abort();
    test_rst_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
